// File: rtl/fow_pkg.sv
// rtl/fow_pkg.sv - shared types, constants and LFSR helpers for the enemy lane logic
//
// Purpose : common definitions for the enemy car stepper and its helpers.
// Contents: enemy_state_t (2-bit FSM encoding), lane width/count,
//           LFSR width and tap mask, LFSR step and spawn-lane helpers.
package fow_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      MOVE = 2'd2,
      HIT  = 2'd3
   } enemy_state_t;

   localparam int LANE_W    = 2;
   localparam int NUM_LANES = 3;
   localparam int LFSR_W    = 8;

   // Taps 8,6,5,4 (1-based) -> bits 7,5,4,3 of the register.
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

   // Fibonacci form: XOR of the tapped bits shifts in at bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
      return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
   endfunction

   // Two LFSR bits give four codes but the road has three lanes;
   // the unused code folds onto the middle lane.
   function automatic logic [LANE_W-1:0] spawn_lane(input logic [LFSR_W-1:0] l);
      logic [LANE_W-1:0] raw;
      raw = l[LANE_W-1:0];
      return (raw >= LANE_W'(NUM_LANES)) ? 2'b01 : raw;
   endfunction

endpackage

// File: rtl/enemy_lane_stepper_edge_tick_sync.sv
// rtl/enemy_lane_stepper_edge_tick_sync.sv - two-flop synchroniser with rising-edge tick
//
// Purpose : brings a slow asynchronous square wave into the clock_in domain
//           and produces a one-cycle tick per rising edge of it.
// Ports   : clock_in  in  system clock
//           rst_n     in  synchronous active-low reset
//           async_in  in  asynchronous square wave
//           tick      out one-cycle pulse, high while s2=1 and s3=0
module edge_tick_sync (
   input  logic clock_in,
   input  logic rst_n,
   input  logic async_in,
   output logic tick
);

   logic s1;
   logic s2;
   logic s3;

   // s1/s2 form the metastability chain; s3 is only the history for
   // edge detection and never sees the raw asynchronous input.
   always_ff @(posedge clock_in) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= async_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign tick = s2 & ~s3;

endmodule

// File: rtl/enemy_lane_stepper.sv
// rtl/enemy_lane_stepper.sv - moves one enemy car down a 3-lane road on slow clock ticks
//
// Purpose : synchronises the enemy clock into a step tick, spawns an enemy
//           in a pseudo-random lane, walks it down one row per tick and
//           reports collision with the player or a clean pass.
// Ports   : clock_in     in  system clock
//           rst_n        in  synchronous active-low reset
//           enemy_clk    in  slow square wave, asynchronous to clock_in
//           enable       in  game running; low returns to IDLE
//           player_lane  in  player lane 0..2 (3 never matches)
//           enemy_row    out current enemy row 0..ROWS-1
//           enemy_lane   out current enemy lane 0..2
//           enemy_active out enemy is on screen
//           collision    out one-cycle pulse on impact
//           passed       out one-cycle pulse when the enemy leaves the bottom row
module enemy_lane_stepper
   import fow_pkg::*;
#(
   parameter int                ROWS       = 16,
   parameter int                ROW_W      = 4,
   parameter int                PLAYER_ROW = 14,
   parameter int                SPAWN_GAP  = 3,
   parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'hA5
) (
   input  logic              clock_in,
   input  logic              rst_n,
   input  logic              enemy_clk,
   input  logic              enable,
   input  logic [LANE_W-1:0] player_lane,
   output logic [ROW_W-1:0]  enemy_row,
   output logic [LANE_W-1:0] enemy_lane,
   output logic              enemy_active,
   output logic              collision,
   output logic              passed
);

   // Wide enough to hold SPAWN_GAP, and at least one bit for SPAWN_GAP=0.
   localparam int GAP_W = $clog2(SPAWN_GAP + 2);

   localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
   localparam logic [ROW_W-1:0] HIT_ROW    = ROW_W'(PLAYER_ROW);
   localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(SPAWN_GAP);

   logic step_tick;

   edge_tick_sync u_sync (
      .clock_in (clock_in),
      .rst_n    (rst_n),
      .async_in (enemy_clk),
      .tick     (step_tick)
   );

   enemy_state_t      state,     state_n;
   logic [ROW_W-1:0]  row_n;
   logic [LANE_W-1:0] lane_n;
   logic              active_n;
   logic              collision_n;
   logic              passed_n;
   logic [GAP_W-1:0]  gap,       gap_n;
   logic [LFSR_W-1:0] lfsr,      lfsr_n;

   always_ff @(posedge clock_in) begin
      if (!rst_n) begin
         state        <= IDLE;
         enemy_row    <= '0;
         enemy_lane   <= '0;
         enemy_active <= 1'b0;
         collision    <= 1'b0;
         passed       <= 1'b0;
         gap          <= '0;
         lfsr         <= LFSR_SEED;
      end else begin
         state        <= state_n;
         enemy_row    <= row_n;
         enemy_lane   <= lane_n;
         enemy_active <= active_n;
         collision    <= collision_n;
         passed       <= passed_n;
         gap          <= gap_n;
         lfsr         <= lfsr_n;
      end
   end

   always_comb begin
      state_n     = state;
      row_n       = enemy_row;
      lane_n      = enemy_lane;
      active_n    = enemy_active;
      collision_n = 1'b0;
      passed_n    = 1'b0;
      gap_n       = gap;
      // The LFSR free-runs on ticks regardless of state, so the lane chosen
      // at a spawn depends on how long the game has been ticking.
      lfsr_n      = step_tick ? lfsr_step(lfsr) : lfsr;

      if (!enable) begin
         state_n  = IDLE;
         row_n    = '0;
         lane_n   = '0;
         active_n = 1'b0;
         gap_n    = '0;
      end else begin
         case (state)
            IDLE: begin
               active_n = 1'b0;
               gap_n    = GAP_RELOAD;
               state_n  = WAIT;
            end
            WAIT: begin
               if (step_tick) begin
                  if (gap == '0) begin
                     row_n    = '0;
                     lane_n   = spawn_lane(lfsr);
                     active_n = 1'b1;
                     state_n  = MOVE;
                  end else begin
                     gap_n = gap - GAP_W'(1);
                  end
               end
            end
            MOVE: begin
               if (step_tick) begin
                  // Impact is checked before the exit row so that a player
                  // row on the last line still reports a collision.
                  if ((enemy_row == HIT_ROW) && (enemy_lane == player_lane)) begin
                     collision_n = 1'b1;
                     state_n     = HIT;
                  end else if (enemy_row == LAST_ROW) begin
                     passed_n = 1'b1;
                     active_n = 1'b0;
                     gap_n    = GAP_RELOAD;
                     state_n  = WAIT;
                  end else begin
                     row_n = enemy_row + ROW_W'(1);
                  end
               end
            end
            HIT: begin
               // Frozen so the crash stays on screen until the game stops.
               active_n = 1'b1;
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_enemy_lane_stepper.sv
// tb/tb_enemy_lane_stepper.sv - directed self-checking bench for enemy_lane_stepper
module tb_enemy_lane_stepper;
   import fow_pkg::*;

   logic       clock_in;
   logic       rst_n;
   logic       enemy_clk;
   logic       enable;
   logic [1:0] player_lane;
   logic [3:0] enemy_row;
   logic [1:0] enemy_lane;
   logic       enemy_active;
   logic       collision;
   logic       passed;

   enemy_lane_stepper dut (
      .clock_in     (clock_in),
      .rst_n        (rst_n),
      .enemy_clk    (enemy_clk),
      .enable       (enable),
      .player_lane  (player_lane),
      .enemy_row    (enemy_row),
      .enemy_lane   (enemy_lane),
      .enemy_active (enemy_active),
      .collision    (collision),
      .passed       (passed)
   );

   initial clock_in = 1'b0;
   always #5 clock_in = ~clock_in;

   int errors = 0;
   int checks = 0;

   logic [7:0] m_lfsr;
   logic [7:0] m_prev;
   logic [1:0] m_lane;

   logic       pre_active;
   logic [3:0] s_row;
   logic [1:0] s_lane;
   logic       s_active, s_coll, s_pass;
   logic       s_coll2, s_pass2;

   bit cnt_en = 1'b0;
   int tick_cnt = 0;

   always @(negedge clock_in)
      if (cnt_en && dut.step_tick) tick_cnt++;

   typedef struct {
      logic [1:0] pl;
      bit         chk_row;
      logic [3:0] row;
      logic       active;
      logic       passed;
      logic       coll;
      bit         spawn;
   } vec_t;

   vec_t tbl [24];

   function automatic logic [7:0] model_next(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   function automatic logic [1:0] model_lane(input logic [7:0] l);
      return (l[1:0] == 2'b11) ? 2'b01 : l[1:0];
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Entered and left at posedge+1. One full enemy_clk period of 2*half cycles.
   task automatic step(input int half);
      m_prev = m_lfsr;
      m_lfsr = model_next(m_lfsr);
      enemy_clk = 1'b1;
      repeat (2) @(posedge clock_in);
      #1;
      pre_active = enemy_active;
      @(posedge clock_in);
      #1;
      s_row    = enemy_row;
      s_lane   = enemy_lane;
      s_active = enemy_active;
      s_coll   = collision;
      s_pass   = passed;
      @(posedge clock_in);
      #1;
      s_coll2 = collision;
      s_pass2 = passed;
      repeat (half - 4) @(posedge clock_in);
      #1;
      enemy_clk = 1'b0;
      repeat (half) @(posedge clock_in);
      #1;
   endtask

   task automatic cycle();
      @(posedge clock_in);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit [2:0] seen;
      int       pulses;

      for (int i = 0; i < 24; i++) begin
         tbl[i].pl      = 2'd0;
         tbl[i].chk_row = 1'b1;
         tbl[i].row     = 4'd0;
         tbl[i].active  = 1'b0;
         tbl[i].passed  = 1'b0;
         tbl[i].coll    = 1'b0;
         tbl[i].spawn   = 1'b0;
         if (i < 3) begin
            tbl[i].row = 4'd0;
         end else if (i < 19) begin
            tbl[i].row    = 4'(i - 3);
            tbl[i].active = 1'b1;
            tbl[i].spawn  = (i == 3);
         end else if (i == 19) begin
            tbl[i].chk_row = 1'b0;
            tbl[i].passed  = 1'b1;
         end else if (i < 23) begin
            tbl[i].chk_row = 1'b0;
         end else begin
            tbl[i].row    = 4'd0;
            tbl[i].active = 1'b1;
            tbl[i].spawn  = 1'b1;
         end
      end

      rst_n       = 1'b0;
      enable      = 1'b0;
      enemy_clk   = 1'b0;
      player_lane = 2'd0;
      m_lfsr      = 8'hA5;
      m_lane      = 2'd0;
      repeat (3) @(posedge clock_in);
      #1;
      chk("rst_row", enemy_row, 0);
      chk("rst_lane", enemy_lane, 0);
      chk("rst_active", enemy_active, 0);
      chk("rst_collision", collision, 0);
      chk("rst_passed", passed, 0);
      chk("rst_state", int'(dut.state), int'(IDLE));
      chk("rst_lfsr", dut.lfsr, 8'hA5);
      rst_n = 1'b1;
      cycle();
      chk("idle_after_rst", int'(dut.state), int'(IDLE));

      // Spawn, full descent without impact, pass, wait, respawn.
      enable = 1'b1;
      cycle();
      for (int i = 0; i < 24; i++) begin
         player_lane = tbl[i].pl;
         step(20);
         if (tbl[i].chk_row) chk($sformatf("t%0d_row", i + 1), s_row, tbl[i].row);
         chk($sformatf("t%0d_active", i + 1), s_active, tbl[i].active);
         chk($sformatf("t%0d_passed", i + 1), s_pass, tbl[i].passed);
         chk($sformatf("t%0d_collision", i + 1), s_coll, tbl[i].coll);
         chk($sformatf("t%0d_passed_width", i + 1), s_pass2, 0);
         chk($sformatf("t%0d_coll_width", i + 1), s_coll2, 0);
         if (tbl[i].spawn) begin
            m_lane = model_lane(m_prev);
            chk($sformatf("t%0d_pre_active", i + 1), pre_active, 0);
         end
         if (tbl[i].active) chk($sformatf("t%0d_lane", i + 1), s_lane, m_lane);
         if (i == 3) chk("first_lane_hand", s_lane, 2);
      end

      // Player sits in the enemy's lane: impact at the player row.
      player_lane = m_lane;
      for (int r = 1; r <= 14; r++) begin
         step(20);
         chk($sformatf("hit_run_row%0d", r), s_row, r);
         chk($sformatf("hit_run_coll%0d", r), s_coll, 0);
      end
      step(20);
      chk("hit_collision", s_coll, 1);
      chk("hit_coll_width", s_coll2, 0);
      chk("hit_row", s_row, 14);
      chk("hit_active", s_active, 1);
      chk("hit_passed", s_pass, 0);
      chk("hit_state", int'(dut.state), int'(HIT));
      step(20);
      chk("hit_hold_row", s_row, 14);
      chk("hit_hold_active", s_active, 1);
      chk("hit_hold_coll", s_coll, 0);
      enable = 1'b0;
      cycle();
      chk("disable_state", int'(dut.state), int'(IDLE));
      chk("disable_active", enemy_active, 0);
      chk("disable_row", enemy_row, 0);
      chk("disable_lane", enemy_lane, 0);
      chk("disable_coll", collision, 0);

      // Reset mid-move at row 7, then the lane sequence restarts.
      player_lane = 2'd3;
      enable = 1'b1;
      cycle();
      repeat (11) step(20);
      chk("pre_reset_row", enemy_row, 7);
      chk("pre_reset_state", int'(dut.state), int'(MOVE));
      rst_n  = 1'b0;
      enable = 1'b0;
      cycle();
      rst_n  = 1'b1;
      m_lfsr = 8'hA5;
      chk("mid_rst_row", enemy_row, 0);
      chk("mid_rst_lane", enemy_lane, 0);
      chk("mid_rst_active", enemy_active, 0);
      chk("mid_rst_coll", collision, 0);
      chk("mid_rst_passed", passed, 0);
      chk("mid_rst_state", int'(dut.state), int'(IDLE));
      chk("mid_rst_lfsr", dut.lfsr, 8'hA5);
      enable = 1'b1;
      cycle();
      repeat (4) step(20);
      m_lane = model_lane(m_prev);
      chk("rerun_active", s_active, 1);
      chk("rerun_lane_hand", s_lane, 2);

      // Many spawns with a faster enemy clock.
      seen = '0;
      for (int n = 0; n < 200; n++) begin
         enable = 1'b0;
         cycle();
         enable = 1'b1;
         cycle();
         repeat (4) step(4);
         m_lane = model_lane(m_prev);
         chk($sformatf("spawn%0d_active", n), s_active, 1);
         chk($sformatf("spawn%0d_lane", n), s_lane, m_lane);
         chk($sformatf("spawn%0d_lane_range", n), int'(s_lane < 2'd3), 1);
         chk($sformatf("spawn%0d_lfsr_nz", n), int'(dut.lfsr != 8'h00), 1);
         if (s_lane < 2'd3) seen[s_lane] = 1'b1;
      end
      chk("all_lanes_seen", seen, 3'b111);

      // Constant-high enemy clock gives one tick; disable mid-WAIT is silent.
      enable = 1'b0;
      cycle();
      enable = 1'b1;
      cycle();
      chk("wait_entered", int'(dut.state), int'(WAIT));
      tick_cnt  = 0;
      cnt_en    = 1'b1;
      pulses    = 0;
      enemy_clk = 1'b1;
      repeat (20) begin
         cycle();
         if (passed || collision) pulses++;
      end
      chk("still_wait", int'(dut.state), int'(WAIT));
      enable = 1'b0;
      cycle();
      if (passed || collision) pulses++;
      chk("mid_wait_idle", int'(dut.state), int'(IDLE));
      chk("mid_wait_active", enemy_active, 0);
      repeat (80) begin
         cycle();
         if (passed || collision) pulses++;
      end
      cnt_en = 1'b0;
      chk("single_tick", tick_cnt, 1);
      chk("no_pulse", pulses, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
